mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the multicycle RISC-V core: answers load/store requests issued by the control unit with a one-transaction-at-a-time valid/ready handshake. It holds a word-addressed RAM, decodes RV32I load/store width from funct3, applies byte-lane write masks, and sign- or zero-extends load data. It models configurable wait states so the core's FSM can be exercised against slow memory.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two.
- LATENCY, 2: wait cycles between acceptance and response; 0..15.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_funct3  input  3  width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts response
- rsp_rdata  output  32  extended load data; 0 for stores
- rsp_error  output  1  request faulted (misaligned or illegal funct3)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch write, addr, wdata, funct3; load counter with LATENCY; go to WAIT if LATENCY>0, else RESP.
- WAIT: req_ready=0; counter decrements each cycle; at counter==1 go to RESP.
- Entry to RESP (the transition edge): stores commit to RAM with byte mask; loads read the addressed word, shift by addr[1:0], extend per funct3, register into rsp_rdata.
- RESP: rsp_valid=1, held with stable rsp_rdata/rsp_error until rsp_ready; on rsp_valid&&rsp_ready return to IDLE.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
- Write masks: SB 1 lane at addr[1:0]; SH lanes {1:0} or {3:2}; SW all lanes.
- Illegal funct3 (011, 110, 111; or 100/101 with req_write=1): rsp_error=1, no RAM write, rsp_rdata=0.
- Misalignment (SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0): see Configuration.
- No request queuing: req_valid during WAIT/RESP is ignored; requester must hold it until req_ready.

## Timing
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_error=0, counter=0. RAM contents not reset.
- Reset mid-operation: transaction dropped; a store not yet at RESP entry never commits; a store already committed stays.
- Accept-to-rsp_valid latency: LATENCY+1 cycles (LATENCY=0 -> rsp_valid the cycle after acceptance).
- Back-to-back: minimum 1 IDLE cycle between response handshake and next acceptance; throughput one transaction per LATENCY+2 cycles with rsp_ready tied high.
- Load after store to same word observes the new data (store commits before the load is accepted).

## Configuration
- MISALIGN_TRAP_EN defined: misaligned access gives rsp_error=1, no RAM write, rsp_rdata=0.
- Undefined: misaligned address low bits forced to natural alignment (bit 0 cleared for half, bits 1:0 for word); access proceeds, rsp_error only for illegal funct3.

## Structure
- Package mem_pkg: state enum (IDLE, WAIT, RESP), funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), width of counter.
- Sub-module load_extend: combinational word + addr[1:0] + funct3 -> extended 32-bit load data; reused by the core's writeback path.
- RAM inferred as reg array with per-byte write enables inside mem_responder.

## Test plan
- LATENCY=2, SW 0xDEADBEEF @0x10 then LW @0x10 -> rsp_valid 3 cycles after each accept; load returns 0xDEADBEEF, rsp_error=0.
- After above, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF.
- LW @0x12 with MISALIGN_TRAP_EN -> rsp_error=1, rsp_rdata=0; without it -> returns word @0x10, rsp_error=0.
- rsp_ready held low 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; new req_valid ignored until return to IDLE.
- SW issued, rst_n pulsed low during WAIT -> outputs at reset values immediately; subsequent LW to that address returns prior contents.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, RV32I
// load/store funct3 encodings and the wait-state counter width.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // LATENCY is limited to 0..15
   localparam int CNT_W = 4;

endpackage

// File: rtl/load_extend.sv
// Load data alignment: selects the addressed byte/half from a RAM word and
// sign- or zero-extends it per funct3. Shared with the core's writeback path.
module load_extend
   import mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   assign shifted = word >> {offset, 3'b000};

   always_comb begin
      data = '0;
      case (funct3)
         F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   data = {24'b0, shifted[7:0]};
         F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   data = {16'b0, shifted[15:0]};
         F3_W:    data = shifted;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed RAM responder with valid/ready handshake and LATENCY wait states.
// Optional macro MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t             state, state_nx;
   logic [CNT_W-1:0]   cnt;
   logic               lat_write;
   logic [AW+1:0]      lat_addr;
   logic [31:0]        lat_wdata;
   logic [2:0]         lat_f3;

   logic [31:0]        mem [DEPTH_WORDS];

   // With LATENCY=0 the commit happens on the accept edge, so the live request is used there
   logic               cur_write;
   logic [AW+1:0]      cur_addr;
   logic [31:0]        cur_wdata;
   logic [2:0]         cur_f3;

   always_comb begin
      cur_write = lat_write;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
      cur_f3    = lat_f3;
      if (state == IDLE) begin
         cur_write = req_write;
         cur_addr  = req_addr[AW+1:0];
         cur_wdata = req_wdata;
         cur_f3    = req_funct3;
      end
   end

   logic          illegal, misalign, fault, commit;
   logic [1:0]    off;
   logic [3:0]    be;
   logic [31:0]   wword, ld_data;
   logic [AW-1:0] widx;

   always_comb begin
      illegal = 1'b0;
      case (cur_f3)
         F3_B, F3_H, F3_W: illegal = 1'b0;
         F3_BU, F3_HU:     illegal = cur_write;
         default:          illegal = 1'b1;
      endcase

      misalign = 1'b0;
      case (cur_f3)
         F3_H, F3_HU: misalign = cur_addr[0];
         F3_W:        misalign = |cur_addr[1:0];
         default:     misalign = 1'b0;
      endcase

      off = cur_addr[1:0];
`ifdef MISALIGN_TRAP_EN
      fault = illegal | misalign;
`else
      fault = illegal;
      case (cur_f3)
         F3_H, F3_HU: off[0] = 1'b0;
         F3_W:        off    = 2'b00;
         default:     off    = cur_addr[1:0];
      endcase
`endif

      be    = 4'b0000;
      wword = cur_wdata;
      case (cur_f3)
         F3_B: begin
            be    = 4'b0001 << off;
            wword = {4{cur_wdata[7:0]}};
         end
         F3_H: begin
            be    = off[1] ? 4'b1100 : 4'b0011;
            wword = {2{cur_wdata[15:0]}};
         end
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   assign widx = cur_addr[AW+1:2];

   load_extend u_load_extend (
      .word   (mem[widx]),
      .offset (off),
      .funct3 (cur_f3),
      .data   (ld_data)
   );

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = (LATENCY == 0) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt <= CNT_W'(1)) state_nx = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign commit = (state_nx == RESP) && (state != RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_f3    <= '0;
         rsp_rdata <= '0;
         rsp_error <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr[AW+1:0];
            lat_wdata <= req_wdata;
            lat_f3    <= req_funct3;
            cnt       <= CNT_W'(LATENCY);
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (commit) begin
            rsp_error <= fault;
            rsp_rdata <= (cur_write || fault) ? 32'd0 : ld_data;
         end
      end
   end

   // RAM is not reset; rst_n gating keeps a store from committing while reset is held
   always_ff @(posedge clk) begin
      if (commit && rst_n && cur_write && !fault) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder (LATENCY=2, DEPTH_WORDS=1024).
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_ready, rsp_valid, rsp_error;
   logic [31:0] rsp_rdata;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_error  (rsp_error)
   );

   typedef struct {
      string       name;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // One full transaction: accept, measure latency, check response, handshake.
   task automatic run(input vec_t v);
      int n;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({v.name, "_req_ready"}, 32'(req_ready), 32'd1);
      req_write  = v.wr;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      req_funct3 = v.f3;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({v.name, "_latency"}, 32'(n), 32'd3);
      chk({v.name, "_rdata"}, rsp_rdata, v.exp_rd);
      chk({v.name, "_error"}, 32'(rsp_error), 32'(v.exp_err));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({v.name, "_rsp_valid_clr"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      vec_t v;
      logic [31:0] held;

      tv.push_back('{"sw_10",    1'b1, 32'h10,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
      tv.push_back('{"lw_10",    1'b0, 32'h10,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
      tv.push_back('{"lb_13",    1'b0, 32'h13,   32'h0,        3'b000, 32'hFFFFFFDE, 1'b0});
      tv.push_back('{"lbu_13",   1'b0, 32'h13,   32'h0,        3'b100, 32'h000000DE, 1'b0});
      tv.push_back('{"lh_12",    1'b0, 32'h12,   32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
      tv.push_back('{"lhu_10",   1'b0, 32'h10,   32'h0,        3'b101, 32'h0000BEEF, 1'b0});
      tv.push_back('{"sb_11",    1'b1, 32'h11,   32'h55,       3'b000, 32'h0,        1'b0});
      tv.push_back('{"lw_10b",   1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0});
`ifdef MISALIGN_TRAP_EN
      tv.push_back('{"lw_12mis", 1'b0, 32'h12,   32'h0,        3'b010, 32'h0,        1'b1});
      tv.push_back('{"lh_13mis", 1'b0, 32'h13,   32'h0,        3'b001, 32'h0,        1'b1});
`else
      tv.push_back('{"lw_12mis", 1'b0, 32'h12,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0});
      tv.push_back('{"lh_13mis", 1'b0, 32'h13,   32'h0,        3'b001, 32'hFFFFDEAD, 1'b0});
`endif
      tv.push_back('{"ld_f3_011", 1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1});
      tv.push_back('{"st_f3_101", 1'b1, 32'h10,  32'h0,        3'b101, 32'h0,        1'b1});
      tv.push_back('{"lw_10c",   1'b0, 32'h10,   32'h0,        3'b010, 32'hDEAD55EF, 1'b0});
      tv.push_back('{"sw_14",    1'b1, 32'h14,   32'h0,        3'b010, 32'h0,        1'b0});
      tv.push_back('{"sh_16",    1'b1, 32'h16,   32'hFFFF1234, 3'b001, 32'h0,        1'b0});
      tv.push_back('{"sb_14",    1'b1, 32'h14,   32'hFFFFFF80, 3'b000, 32'h0,        1'b0});
      tv.push_back('{"lw_14",    1'b0, 32'h14,   32'h0,        3'b010, 32'h12340080, 1'b0});
      tv.push_back('{"lb_14",    1'b0, 32'h14,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
      tv.push_back('{"lh_16",    1'b0, 32'h16,   32'h0,        3'b001, 32'h00001234, 1'b0});
      tv.push_back('{"lh_10",    1'b0, 32'h10,   32'h0,        3'b001, 32'h000055EF, 1'b0});
      tv.push_back('{"lw_wrap",  1'b0, 32'h1010, 32'h0,        3'b010, 32'hDEAD55EF, 1'b0});
`ifdef MISALIGN_TRAP_EN
      tv.push_back('{"sw_15mis", 1'b1, 32'h15,   32'hAAAAAAAA, 3'b010, 32'h0,        1'b1});
      tv.push_back('{"lw_14b",   1'b0, 32'h14,   32'h0,        3'b010, 32'h12340080, 1'b0});
`else
      tv.push_back('{"sw_15mis", 1'b1, 32'h15,   32'hAAAAAAAA, 3'b010, 32'h0,        1'b0});
      tv.push_back('{"lw_14b",   1'b0, 32'h14,   32'h0,        3'b010, 32'hAAAAAAAA, 1'b0});
`endif

      // Reset state
      #12;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_error", 32'(rsp_error), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < tv.size(); i++) run(tv[i]);

      // Response stall: rsp_ready low 5 cycles while a competing store is offered
      v = '{"lw_stall", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0};
      req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_write = 1'b1; req_wdata = 32'h11111111;
      for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
      held = rsp_rdata;
      chk("stall_first_rdata", held, 32'hDEAD55EF);
      for (int c = 0; c < 5; c++) begin
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, held);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("stall_back_idle", 32'(req_ready), 32'd1);
      run(v);

      // Reset during WAIT drops an in-flight store
      req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("midrst_in_wait", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'd0);
      chk("midrst_error", 32'(rsp_error), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run('{"lw_after_rst", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
